aes_encrypt_iter: RTL

- Iterative AES block-cipher encryption core.
- Accepts one 128-bit plaintext and one key per transaction over a valid/ready handshake.
- Runs one cipher round per clock on a single shared round datapath, with on-the-fly key expansion.
- Key size (128/192/256) is set by parameter. Sits above the existing single-round datapath modules and replaces per-round unrolled instantiation.

---
 rtl/aes_pkg.sv | 92 +++++++++
 rtl/aes_key_sched.sv | 54 +++++
 rtl/aes_encrypt_iter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, S-box and Rcon tables, round-step functions.
// Optional round tap in aes_encrypt_iter is enabled with `define AES_ROUND_TAP_EN.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  function automatic int nk_of(input int key_bits);
    return key_bits / 32'sd32;
  endfunction

  function automatic int nr_of(input int key_bits);
    return key_bits / 32'sd32 + 32'sd6;
  endfunction

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Out-of-range indices return zero; they only occur while the schedule is idle.
  function automatic logic [7:0] rcon(input logic [6:0] q);
    if (q >= 7'd1 && q <= 7'd10) return RCON[q[3:0]];
    else return 8'h00;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[127-8*b -: 8] = SBOX[s[127-8*b -: 8]];
    return r;
  endfunction

  // Byte b = 4*column + row; row rr rotates left by rr columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        r[127-8*(4*c+rr) -: 8] = s[127-8*(4*((c+rr)%4)+rr) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_key_sched.sv
// On-the-fly AES key expansion: keeps an NK-word window and emits one 4-word round key per step.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [KEY_BITS-1:0] key,
  output logic [127:0]        round_key
);

  localparam int NK = nk_of(KEY_BITS);
  localparam logic [6:0] NK_W = 7'(NK);

  logic [31:0] win_r [NK];
  logic [31:0] win_next_s [NK];
  logic [6:0]  idx_r;

  function automatic logic [31:0] expand_word(input logic [31:0] prev, input logic [31:0] back,
                                              input logic [6:0] i);
    logic [31:0] t;
    if (i % NK_W == 7'd0) t = sub_word(rot_word(prev)) ^ {rcon(i / NK_W), 24'h000000};
    else if (NK == 32'sd8 && i % NK_W == 7'd4) t = sub_word(prev);
    else t = prev;
    return back ^ t;
  endfunction

  // Window holds w[idx-NK..idx-1]; the round key is always words 4..7 of window+new words.
  always_comb begin
    logic [31:0] c [NK+4];
    for (int k = 0; k < NK; k++) c[k] = win_r[k];
    for (int n = 0; n < 4; n++) c[NK+n] = expand_word(c[NK+n-1], c[n], idx_r + 7'(n));
    for (int k = 0; k < NK; k++) win_next_s[k] = c[k+4];
    round_key = {c[4], c[5], c[6], c[7]};
  end

  // Window and word index: load from the key, then slide by four words per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NK; k++) win_r[k] <= 32'h0;
      idx_r <= 7'd0;
    end else if (load) begin
      for (int k = 0; k < NK; k++) win_r[k] <= key[KEY_BITS-1-32*k -: 32];
      idx_r <= NK_W;
    end else if (step) begin
      for (int k = 0; k < NK; k++) win_r[k] <= win_next_s[k];
      idx_r <= idx_r + 7'd4;
    end
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryption core, one round per clock with on-the-fly key expansion.
// `define AES_ROUND_TAP_EN adds the dbg_valid/dbg_round/dbg_state round tap.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
`ifdef AES_ROUND_TAP_EN
  output logic                dbg_valid,
  output logic [3:0]          dbg_round,
  output logic [127:0]        dbg_state,
`endif
  output logic                busy
);

  localparam int NR = nr_of(KEY_BITS);
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  if (!(KEY_BITS == 32'sd128 || KEY_BITS == 32'sd192 || KEY_BITS == 32'sd256)) begin : g_bad_key_bits
    $fatal(1, "aes_encrypt_iter: KEY_BITS must be 128, 192 or 256");
  end

  aes_state_e   state_r, state_next_s;
  logic [127:0] data_r, sr_s, next_data_s, round_key_s;
  logic [3:0]   round_r;
  logic         load_s, step_s, last_s;

  aes_key_sched #(.KEY_BITS(KEY_BITS)) u_key_sched (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .step      (step_s),
    .key       (in_key),
    .round_key (round_key_s)
  );

  // Next-state and key-schedule controls
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready) begin
          load_s       = 1'b1;
          state_next_s = ROUND;
        end else begin
          state_next_s = IDLE;
        end
      end
      ROUND: begin
        step_s = 1'b1;
        if (last_s) state_next_s = DONE;
        else state_next_s = ROUND;
      end
      DONE: begin
        if (out_ready) state_next_s = IDLE;
        else state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Shared round datapath; the final round bypasses MixColumns
  always_comb begin
    last_s = (round_r == LAST_ROUND);
    sr_s   = shift_rows(sub_bytes(data_r));
    if (last_s) next_data_s = add_round_key(sr_s, round_key_s);
    else next_data_s = add_round_key(mix_columns(sr_s), round_key_s);
  end

  // State register, round counter and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      data_r    <= 128'h0;
      round_r   <= 4'd0;
      out_data  <= 128'h0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      in_ready  <= (state_next_s == IDLE);
      out_valid <= (state_next_s == DONE);
      busy      <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (load_s) begin
            data_r  <= add_round_key(in_data, in_key[KEY_BITS-1 -: 128]);
            round_r <= 4'd1;
          end
        end
        ROUND: begin
          if (last_s) begin
            out_data <= next_data_s;
          end else begin
            data_r  <= next_data_s;
            round_r <= round_r + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AES_ROUND_TAP_EN
  // Round tap: one registered sample of each round result
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_valid <= 1'b0;
      dbg_round <= 4'd0;
      dbg_state <= 128'h0;
    end else begin
      dbg_valid <= (state_r == ROUND);
      if (state_r == ROUND) begin
        dbg_round <= round_r;
        dbg_state <= next_data_s;
      end
    end
  end
`endif

endmodule
